// File: rtl/edge_value_writer.sv
// rtl/edge_value_writer.sv - writes 28 streamed edge values to the border pixels of an 8x8 block
module edge_value_writer #(
  parameter int FRAME_WIDTH = 320,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [4:0]            edge_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [2:0]            col;
  logic                  side_span;
  logic                  next_row;

  // Indices 8..19 alternate left/right columns; an odd index (7 included) ends a row.
  assign side_span = (edge_index >= 5'd8) && (edge_index <= 5'd19);
  assign next_row  = (edge_index >= 5'd7) && (edge_index <= 5'd19) && edge_index[0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      base       <= '0;
      row_base   <= '0;
      col        <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      edge_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCEPT;
            base       <= base_address;
            row_base   <= '0;
            col        <= '0;
            edge_index <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            state      <= WRITE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b1;
            wr_data    <= in_data;
            wr_address <= base + row_base + ADDR_WIDTH'(col);
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (edge_index == 5'd27) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= ACCEPT;
            in_ready   <= 1'b1;
            edge_index <= edge_index + 5'd1;
            if (next_row) begin
              row_base <= row_base + ROW_STEP;
              col      <= 3'd0;
            end else if (side_span) begin
              col <= 3'd7;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_value_writer.sv
// tb/tb_edge_value_writer.sv - scoreboard bench for edge_value_writer
module tb_edge_value_writer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [16:0] base_address = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        wr_en;
  logic [16:0] wr_address;
  logic [7:0]  wr_data;
  logic [4:0]  edge_index;
  logic        busy;
  logic        done;

  edge_value_writer #(.FRAME_WIDTH(320), .ADDR_WIDTH(17), .DATA_WIDTH(8)) dut (
    .clock(clock), .resetn(resetn), .start(start), .base_address(base_address),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_address(wr_address), .wr_data(wr_data), .edge_index(edge_index),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [4:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          writes_seen = 0;
  int          done_seen = 0;
  logic [16:0] wr_log[32];
  logic        prev_wr_en = 1'b0;

  function automatic int off(input int i);
    if (i < 8) return i;
    else if (i < 20) return (1 + (i - 8) / 2) * 320 + (((i - 8) % 2) != 0 ? 7 : 0);
    else return 7 * 320 + (i - 20);
  endfunction

  // Every write must match the oldest handshake still outstanding.
  always @(negedge clock) begin
    exp_t e;
    if (wr_en) begin
      writes_seen++;
      wr_log[edge_index] = wr_address;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%0d data=%0d idx=%0d, required no write", wr_address, wr_data, edge_index);
      end else begin
        e = exp_q.pop_front();
        if ({wr_address, wr_data, edge_index} !== {e.addr, e.data, e.idx}) begin
          miscompares++;
          $display("FAIL write_content: addr=%0d data=%0d idx=%0d, required addr=%0d data=%0d idx=%0d",
                   wr_address, wr_data, edge_index, e.addr, e.data, e.idx);
        end
      end
      vectors++;
      if (in_ready !== 1'b0 || prev_wr_en) begin
        miscompares++;
        $display("FAIL write_cycle_shape: in_ready=%b prev_wr_en=%b, required 0 0", in_ready, prev_wr_en);
      end
    end
    if (done) done_seen++;
    prev_wr_en = wr_en;
  end

  task automatic feed(input logic [16:0] base, input int gap_max, input int rogue_idx,
                      input bit rogue_done, input int stop_idx, output int done_cycle);
    int k;
    int gap;
    k = 0;
    gap = 0;
    done_cycle = -1;
    start = 1'b1;
    base_address = base;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        done_cycle = cyc;
        if (rogue_done) begin
          start = 1'b1;
          base_address = 17'd5000;
        end
        return;
      end
      if (in_ready) begin
        if (k == stop_idx) begin
          in_valid = 1'b0;
          return;
        end
        if (k == rogue_idx) begin
          start = 1'b1;
          base_address = 17'd5000;
        end
        if (gap > 0) begin
          in_valid = 1'b0;
          in_data = 8'($urandom);
          gap--;
        end else begin
          in_valid = 1'b1;
          in_data = (gap_max > 0) ? 8'($urandom) : 8'(k);
          exp_q.push_back('{17'(base + off(k)), in_data, 5'(k)});
          k++;
          gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        end
      end else begin
        in_valid = (gap_max == 0) || ($urandom_range(0, 1) == 1);
        in_data = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({in_ready, wr_en, busy, done} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: in_ready/wr_en/busy/done=%b, required 0000", {in_ready, wr_en, busy, done});
    end
    vectors++;
    if (wr_address !== 17'd0 || wr_data !== 8'd0 || edge_index !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_values: addr=%0d data=%0d idx=%0d, required 0 0 0", wr_address, wr_data, edge_index);
    end
    resetn = 1'b1;
  endtask

  task automatic test_nominal();
    int dc;
    @(negedge clock);
    writes_seen = 0;
    done_seen = 0;
    feed(17'd0, 0, -1, 1'b0, -1, dc);
    @(negedge clock);
    vectors++;
    if (dc !== 57) begin
      miscompares++;
      $display("FAIL nominal_done_latency: got %0d cycles, required 57", dc);
    end
    vectors++;
    if (writes_seen !== 28 || done_seen !== 1) begin
      miscompares++;
      $display("FAIL nominal_counts: writes=%0d dones=%0d, required 28 1", writes_seen, done_seen);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL nominal_idle_after: busy=%b done=%b pending=%0d, required 0 0 0", busy, done, exp_q.size());
    end
  endtask

  task automatic test_stalled();
    int dc;
    @(negedge clock);
    writes_seen = 0;
    feed(17'd1000, 5, -1, 1'b0, -1, dc);
    @(negedge clock);
    vectors++;
    if (dc < 57 || writes_seen !== 28 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stalled_block: done_cycle=%0d writes=%0d pending=%0d, required >=57 28 0", dc, writes_seen, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    @(negedge clock);
    writes_seen = 0;
    feed(17'd2000, 0, 3, 1'b1, -1, dc);
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_cycle_start: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || writes_seen !== 28 || dc !== 57) begin
      miscompares++;
      $display("FAIL busy_start_block: busy=%b writes=%0d done_cycle=%0d, required 0 28 57", busy, writes_seen, dc);
    end
  endtask

  task automatic test_wrap();
    int dc;
    @(negedge clock);
    feed(17'd131071, 0, -1, 1'b0, -1, dc);
    @(negedge clock);
    vectors++;
    if (wr_log[1] !== 17'd0 || wr_log[8] !== 17'd319 || wr_log[27] !== 17'd2246) begin
      miscompares++;
      $display("FAIL address_wrap: idx1=%0d idx8=%0d idx27=%0d, required 0 319 2246", wr_log[1], wr_log[8], wr_log[27]);
    end
  endtask

  task automatic test_reset_mid_block();
    int dc;
    int done_base;
    @(negedge clock);
    feed(17'd500, 0, -1, 1'b0, 10, dc);
    vectors++;
    if (edge_index !== 5'd10 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_block_position: idx=%0d in_ready=%b, required 10 1", edge_index, in_ready);
    end
    resetn = 1'b0;
    #1;
    done_base = done_seen;
    vectors++;
    if ({in_ready, wr_en, busy, done, edge_index, wr_address, wr_data} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: rdy=%b wr=%b busy=%b done=%b idx=%0d addr=%0d data=%0d, required all 0",
               in_ready, wr_en, busy, done, edge_index, wr_address, wr_data);
    end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (done_seen !== done_base || exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abandoned_block: extra_dones=%0d pending=%0d busy=%b, required 0 0 0",
               done_seen - done_base, exp_q.size(), busy);
    end
    writes_seen = 0;
    feed(17'd64, 0, -1, 1'b0, -1, dc);
    @(negedge clock);
    vectors++;
    if (dc !== 57 || writes_seen !== 28) begin
      miscompares++;
      $display("FAIL post_reset_block: done_cycle=%0d writes=%0d, required 57 28", dc, writes_seen);
    end
  endtask

  task automatic test_idle_quiet();
    in_valid = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      in_data = 8'($urandom);
      vectors++;
      if ({in_ready, wr_en, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_quiet: in_ready/wr_en/busy=%b at cycle %0d, required 000", {in_ready, wr_en, busy}, c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stalled();
    test_start_while_busy();
    test_wrap();
    test_reset_mid_block();
    test_idle_quiet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_value_writer.md
# edge_value_writer

Write-side counterpart of the edge-value read sequencer. Accepts a stream of 28 edge values over a valid/ready handshake and writes each one to frame memory. The 28 targets are the border pixels of an 8x8 block whose top-left pixel is at `base_address`. The block sits between the edge-processing datapath and the frame-buffer write port, and visits border pixels in the same order the read sequencer uses.

## Interface
Parameters:
- FRAME_WIDTH, 320: pixels per frame row; vertical step between block rows.
- ADDR_WIDTH, 17: frame-memory address width.
- DATA_WIDTH, 8: width of one edge value.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  request a block write; sampled only in IDLE.
- base_address  input  ADDR_WIDTH  top-left pixel address of the block; latched on accepted start.
- in_valid  input  1  in_data holds a valid edge value.
- in_data  input  DATA_WIDTH  edge value.
- in_ready  output  1  writer can take a value this cycle.
- wr_en  output  1  frame-memory write strobe, one cycle per value.
- wr_address  output  ADDR_WIDTH  write address; valid while wr_en=1.
- wr_data  output  DATA_WIDTH  write data; valid while wr_en=1.
- edge_index  output  5  index 0..27 of the value currently expected or being written.
- busy  output  1  high from accepted start until the done cycle, inclusive.
- done  output  1  one-cycle pulse after the 28th write.

## Operation
- States and outputs:
  - IDLE: busy=0, in_ready=0, wr_en=0.
  - ACCEPT: in_ready=1, busy=1.
  - WRITE: wr_en=1, busy=1.
  - DONE: done=1, busy=1.
- Transitions:
  - IDLE -> ACCEPT on start=1. Latch base_address; clear edge_index to 0.
  - ACCEPT -> WRITE when in_valid & in_ready. On the same edge, register wr_data=in_data and wr_address=base+offset(edge_index).
  - ACCEPT holds while in_valid=0, with no timeout.
  - WRITE -> ACCEPT with edge_index+1 if edge_index<27.
  - WRITE -> DONE if edge_index==27.
  - DONE -> IDLE unconditionally.
- Offset for edge_index i:
  - 0..7: row 0, column i. Offset = i.
  - 8..19: k=i-8; row=1+k/2; column=0 if k is even, 7 if k is odd. Offset = row*FRAME_WIDTH+col.
  - 20..27: row 7, column i-20. Offset = 7*FRAME_WIDTH+(i-20).
- Resulting offsets with FRAME_WIDTH=320: 0..7, 320, 327, 640, 647, 960, 967, 1280, 1287, 1600, 1607, 1920, 1927, 2240..2247.
- Offsets come from a row counter and a column counter, or from a constant function of i. No multiplier on a variable operand.
- Address arithmetic: base+offset, truncated to ADDR_WIDTH, i.e. wraps modulo 2^ADDR_WIDTH. No overflow flag.
- start is ignored in ACCEPT, WRITE and DONE, including during the done cycle. base_address is not re-sampled mid-block.
- in_data presented while in_ready=0 is neither consumed nor written.
- Asynchronous reset at any point:
  - State -> IDLE; all outputs go to their reset values.
  - A partial block is abandoned with no further writes and no done.
  - Memory already written is not rolled back.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_address=0, wr_data=0, edge_index=0, busy=0, done=0.
- start sampled at edge T: in_ready=1 and busy=1 in the cycle after T.
- Handshake completes at edge H: wr_en=1 with address and data for exactly the cycle after H.
- in_ready is low during the WRITE cycle. Maximum throughput is one value per 2 cycles.
- With in_valid held high: start edge + 56 cycles to the last wr_en cycle, then done for 1 cycle, then IDLE.
- Minimum start-to-start spacing is therefore 58 cycles.
- edge_index updates on the edge that leaves WRITE. It is stable throughout each ACCEPT/WRITE pair.
- wr_en is never asserted for more than one consecutive cycle. Across one block it is asserted exactly 28 times.

## Test plan
- Nominal block: base=0, in_valid always 1, in_data=i for value i -> 28 writes to 0..7, 320, 327, …, 1920, 1927, 2240..2247 with data 0..27. done pulses once, 57 cycles after the start edge.
- Stalled source: base=1000, in_valid toggled pseudo-randomly with gaps of up to 5 cycles -> same write sequence at 1000+offset. No write ever occurs without a preceding handshake. in_ready=0 in every WRITE cycle.
- Start while busy: second start with base=5000 asserted at edge_index 3, and again during the done cycle -> all 28 writes use the first base. Module returns to IDLE and ignores the done-cycle start.
- Address wrap: base=131071 -> index 1 writes address 0, index 8 writes 319, index 27 writes 2246.
- Reset mid-block: resetn low at edge_index 10 (mid-ACCEPT) -> outputs take reset values immediately with no done. A subsequent start with base=64 produces a full, correct 28-write block.
- Idle quiet: no start for 100 cycles with in_valid=1 -> in_ready=0, wr_en=0 and busy=0 throughout.
